// File: rtl/calc_cmd_sequencer_if.sv
// Byte-level RX/TX and ALU handshake bundle for the calculator command sequencer.
// master = sequencer side, slave = UART/ALU side.
interface calc_cmd_sequencer_if #(
   parameter int DW = 16
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [1:0]    alu_op;
   logic          alu_start;
   logic          alu_done;
   logic [DW-1:0] alu_result;
   logic          alu_err;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic          seq_busy;

   modport master (
      input  rx_data, rx_valid, alu_done, alu_result, alu_err, tx_busy,
      output alu_a, alu_b, alu_op, alu_start, tx_data, tx_start, seq_busy
   );

   modport slave (
      output rx_data, rx_valid, alu_done, alu_result, alu_err, tx_busy,
      input  alu_a, alu_b, alu_op, alu_start, tx_data, tx_start, seq_busy
   );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Parses "<A><op><B>=" from RX bytes, runs the ALU, converts the result to decimal (DW cycles)
// and streams it to TX, one byte per tx_busy rise/fall; RX bytes other than 'I' are dropped while busy.
module calc_cmd_sequencer #(
   parameter int DW         = 16,
   parameter int MAX_DIGITS = 4
) (
   input logic                  clk,
   input logic                  rst,
   calc_cmd_sequencer_if.master bus
);
   localparam int ND = (DW * 30103 + 99999) / 100000;
   localparam int QN = ND + 2;
   localparam int QW = $clog2(QN + 1);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int SW = $clog2(DW);

   typedef enum logic [2:0] {OPA, OPB, EXEC, WAIT, CONV, SEND} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   acc, opnd_a, bin;
   logic [CW-1:0]   dcnt;
   logic            neg;
   logic [4*ND-1:0] bcd;
   logic [SW-1:0]   ccnt;
   logic [7:0]      q [QN];
   logic [QW-1:0]   q_len, q_idx;
   logic            tx_wait;
   logic [7:0]      tx_hold;
   logic [DW-1:0]   alu_a_r, alu_b_r;
   logic [1:0]      alu_op_r;

   logic       is_digit, is_oper, is_space, is_eq, is_abort, digit_full, swap;
   logic [1:0] op_code;
   logic       take_digit, latch_a, latch_b, fail, latch_res, conv_step, conv_last, tx_go, finish;
   logic [7:0] tx_char;

   assign is_digit   = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
   assign is_oper    = (bus.rx_data == 8'h2B) || (bus.rx_data == 8'h2D) ||
                       (bus.rx_data == 8'h2A) || (bus.rx_data == 8'h2F);
   assign is_space   = (bus.rx_data == 8'h20);
   assign is_eq      = (bus.rx_data == 8'h3D);
   assign is_abort   = bus.rx_valid && (bus.rx_data == 8'h49);
   assign digit_full = (dcnt == CW'(MAX_DIGITS));
   // Subtraction is always issued as larger-minus-smaller; the sign is printed separately.
   assign swap       = (alu_op_r == 2'b01) && (opnd_a < acc);
   assign tx_char    = q[q_idx];

   always_comb begin
      op_code = 2'b00;
      case (bus.rx_data)
         8'h2D:   op_code = 2'b01;
         8'h2A:   op_code = 2'b10;
         8'h2F:   op_code = 2'b11;
         default: op_code = 2'b00;
      endcase
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift the binary MSB in.
   logic [4*ND-1:0] bcd_adj, bcd_sh;
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < ND; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_sh = {bcd_adj[4*ND-2:0], bin[DW-1]};
   end

   logic [7:0]    qb [QN];
   logic [QW-1:0] qb_len;
   logic          lead;
   always_comb begin
      for (int i = 0; i < QN; i++) qb[i] = 8'h00;
      qb_len = '0;
      lead   = 1'b1;
      if (neg) begin
         qb[qb_len] = 8'h2D;
         qb_len     = qb_len + QW'(1);
      end
      for (int i = ND - 1; i >= 0; i--) begin
         if ((bcd_sh[4*i +: 4] != 4'd0) || !lead || (i == 0)) begin
            qb[qb_len] = {4'h3, bcd_sh[4*i +: 4]};
            qb_len     = qb_len + QW'(1);
            lead       = 1'b0;
         end
      end
      qb[qb_len] = 8'h0D;
      qb_len     = qb_len + QW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= OPA;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      take_digit = 1'b0;
      latch_a    = 1'b0;
      latch_b    = 1'b0;
      fail       = 1'b0;
      latch_res  = 1'b0;
      conv_step  = 1'b0;
      conv_last  = 1'b0;
      tx_go      = 1'b0;
      finish     = 1'b0;
      if (is_abort) begin
         state_nxt = OPA;
      end else begin
         case (state)
            OPA, OPB: begin
               if (bus.rx_valid && !is_space) begin
                  if (is_digit) begin
                     if (digit_full) fail = 1'b1;
                     else            take_digit = 1'b1;
                  end else if ((state == OPA) && is_oper && (dcnt != '0)) begin
                     latch_a   = 1'b1;
                     state_nxt = OPB;
                  end else if ((state == OPB) && is_eq && (dcnt != '0)) begin
                     latch_b   = 1'b1;
                     state_nxt = EXEC;
                  end else begin
                     fail = 1'b1;
                  end
               end
            end
            EXEC: state_nxt = WAIT;
            WAIT: begin
               if (bus.alu_done) begin
                  if (bus.alu_err) begin
                     fail = 1'b1;
                  end else begin
                     latch_res = 1'b1;
                     state_nxt = CONV;
                  end
               end
            end
            CONV: begin
               conv_step = 1'b1;
               if (ccnt == SW'(DW - 1)) begin
                  conv_last = 1'b1;
                  state_nxt = SEND;
               end
            end
            SEND: begin
               if (!tx_wait && !bus.tx_busy) begin
                  tx_go = 1'b1;
                  if (q_idx == q_len - QW'(1)) begin
                     finish    = 1'b1;
                     state_nxt = OPA;
                  end
               end
            end
            default: state_nxt = OPA;
         endcase
         if (fail) state_nxt = SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || is_abort || finish) begin
         acc      <= '0;
         dcnt     <= '0;
         opnd_a   <= '0;
         neg      <= 1'b0;
         bin      <= '0;
         bcd      <= '0;
         ccnt     <= '0;
         for (int i = 0; i < QN; i++) q[i] <= 8'h00;
         q_len    <= '0;
         q_idx    <= '0;
         tx_wait  <= 1'b0;
         alu_a_r  <= '0;
         alu_b_r  <= '0;
         alu_op_r <= 2'b00;
      end else begin
         if (take_digit) begin
            acc  <= (acc << 3) + (acc << 1) + DW'(bus.rx_data[3:0]);
            dcnt <= dcnt + CW'(1);
         end
         if (latch_a) begin
            opnd_a   <= acc;
            alu_op_r <= op_code;
            acc      <= '0;
            dcnt     <= '0;
         end
         if (latch_b) begin
            alu_a_r <= swap ? acc : opnd_a;
            alu_b_r <= swap ? opnd_a : acc;
            neg     <= swap;
            acc     <= '0;
            dcnt    <= '0;
         end
         if (latch_res) begin
            bin  <= bus.alu_result;
            bcd  <= '0;
            ccnt <= '0;
         end
         if (conv_step) begin
            bcd  <= bcd_sh;
            bin  <= {bin[DW-2:0], 1'b0};
            ccnt <= ccnt + SW'(1);
            if (conv_last) begin
               q     <= qb;
               q_len <= qb_len;
               q_idx <= '0;
            end
         end
         if (fail) begin
            q[0]    <= 8'h45;
            q[1]    <= 8'h0D;
            q_len   <= QW'(2);
            q_idx   <= '0;
            tx_wait <= 1'b0;
         end
         // Next start is allowed only once tx_busy has been seen high and then low again.
         if (tx_go) begin
            q_idx   <= q_idx + QW'(1);
            tx_wait <= 1'b1;
         end else if (tx_wait && bus.tx_busy) begin
            tx_wait <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        tx_hold <= 8'h00;
      else if (tx_go) tx_hold <= tx_char;
   end

   assign bus.alu_a     = alu_a_r;
   assign bus.alu_b     = alu_b_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.alu_start = (state == EXEC);
   assign bus.tx_start  = tx_go;
   assign bus.tx_data   = tx_go ? tx_char : tx_hold;
   assign bus.seq_busy  = (state != OPA) && (state != OPB);
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: directed expressions plus random ones, with ALU and TX models.
module tb_calc_cmd_sequencer;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   calc_cmd_sequencer_if #(.DW(DW)) bus ();
   calc_cmd_sequencer #(.DW(DW), .MAX_DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_edge = 0;
   string cr;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU model: answers alu_lat cycles after start, unless muted.
   int alu_lat = 3;
   bit alu_mute = 1'b0;
   int pend = 0;
   int alu_cnt = 0;
   int la, lb, lop, start_edge, done_edge;
   always @(posedge clk) begin
      int r;
      bit e;
      bus.alu_done   <= 1'b0;
      bus.alu_err    <= 1'b0;
      bus.alu_result <= '0;
      if (bus.alu_start === 1'b1) begin
         alu_cnt++;
         la = int'(bus.alu_a);
         lb = int'(bus.alu_b);
         lop = int'(bus.alu_op);
         start_edge = cyc;
         pend = alu_lat;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0 && !alu_mute) begin
            e = 1'b0;
            r = 0;
            case (lop)
               0: begin r = la + lb; e = (r > 65535); end
               1: begin r = la - lb; e = (la < lb); end
               2: begin r = la * lb; e = (r > 65535); end
               default: begin e = (lb == 0); r = (lb == 0) ? 0 : la / lb; end
            endcase
            bus.alu_done   <= 1'b1;
            bus.alu_err    <= e;
            bus.alu_result <= r[15:0];
            done_edge = cyc + 1;
         end
      end
   end

   // TX model: busy for 10 cycles starting the cycle after each start.
   int bcnt = 0;
   int last_start = -10;
   int spacing_bad = 0;
   logic [7:0] txq[$];
   int txe[$];
   always @(posedge clk) begin
      if (bus.tx_start === 1'b1) begin
         if (bus.tx_busy === 1'b1 || last_start == cyc - 1) spacing_bad++;
         txq.push_back(bus.tx_data);
         txe.push_back(cyc);
         last_start = cyc;
         bcnt = 10;
         bus.tx_busy <= 1'b1;
      end else if (bcnt > 1) begin
         bcnt--;
      end else begin
         bcnt = 0;
         bus.tx_busy <= 1'b0;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_s(input string tag, input string got, input string exp);
      checks++;
      assert (got == exp) else begin
         errors++;
         $error("FAIL %s: got [%s] expected [%s]", tag, got, exp);
      end
   endtask

   function automatic string hexs(input string s);
      string h = "";
      for (int i = 0; i < s.len(); i++) h = $sformatf("%s%02x ", h, s[i]);
      return h;
   endfunction

   function automatic string got_hex(input int base);
      string h = "";
      for (int i = base; i < txq.size(); i++) h = $sformatf("%s%02x ", h, txq[i]);
      return h;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      last_edge = cyc;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_tx(input int base, input int n);
      int k = 0;
      while (txq.size() < base + n && k < 2000) begin @(negedge clk); k++; end
      k = 0;
      while ((bus.seq_busy !== 1'b0 || bus.tx_busy !== 1'b0) && k < 200) begin @(negedge clk); k++; end
      repeat (2) @(negedge clk);
   endtask

   // Reference: what the calculator should print for A op B, and the ALU operands it should issue.
   task automatic run_expr(input string tag, input string s, input int a, input int b,
                           input int op, input bit lat);
      int base = txq.size();
      int c0 = alu_cnt;
      int eq_edge;
      int ea = a, eb = b, mag = 0;
      bit ng = 1'b0, err = 1'b0;
      string exp;
      case (op)
         0: mag = a + b;
         1: begin ng = (a < b); mag = ng ? b - a : a - b; if (ng) begin ea = b; eb = a; end end
         2: begin mag = a * b; err = (mag > 65535); end
         default: begin err = (b == 0); mag = err ? 0 : a / b; end
      endcase
      exp = err ? {"E", cr} : {ng ? "-" : "", $sformatf("%0d", mag), cr};
      send_str(s);
      eq_edge = last_edge;
      wait_tx(base, exp.len());
      chk({tag, "/launch"}, alu_cnt - c0, 1);
      chk({tag, "/alu_a"}, la, ea);
      chk({tag, "/alu_b"}, lb, eb);
      chk({tag, "/alu_op"}, lop, op);
      chk_s({tag, "/tx"}, got_hex(base), hexs(exp));
      if (lat) begin
         chk({tag, "/start_lat"}, start_edge - eq_edge, 1);
         chk({tag, "/conv_lat"}, txe[base] - done_edge, DW + 1);
      end
   endtask

   task automatic run_err(input string tag, input string s);
      int base = txq.size();
      int c0 = alu_cnt;
      send_str(s);
      wait_tx(base, 2);
      chk({tag, "/launch"}, alu_cnt - c0, 0);
      chk_s({tag, "/tx"}, got_hex(base), hexs({"E", cr}));
   endtask

   initial begin
      int base, k, a, b, op;
      string s, opc;
      cr = $sformatf("%c", 8'h0d);
      rst = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst/alu_start", int'(bus.alu_start), 0);
      chk("rst/tx_start", int'(bus.tx_start), 0);
      chk("rst/seq_busy", int'(bus.seq_busy), 0);
      chk("rst/alu_a", int'(bus.alu_a), 0);
      chk("rst/alu_op", int'(bus.alu_op), 0);
      chk("rst/tx_data", int'(bus.tx_data), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_expr("add", "12+34=", 12, 34, 0, 1'b1);
      run_expr("subneg", "5-9=", 5, 9, 1, 1'b0);
      run_expr("div0", "7/0=", 7, 0, 3, 1'b0);
      run_expr("mul", "2*3=", 2, 3, 2, 1'b0);
      run_err("digits5", "12345");
      run_err("badchar", "4x");
      run_err("eq_in_opa", "=");
      run_expr("zero", "0 * 0 =", 0, 0, 2, 1'b0);

      // Abort mid-SEND after the first character has started.
      base = txq.size();
      send_str("123*45=");
      k = 0;
      while (txq.size() < base + 1 && k < 500) begin @(negedge clk); k++; end
      send_byte(8'h49);
      repeat (40) @(negedge clk);
      chk("abort_send/count", txq.size() - base, 1);
      chk("abort_send/first", (txq.size() > base) ? int'(txq[base]) : -1, 8'h35);
      chk("abort_send/busy", int'(bus.seq_busy), 0);

      // Abort in WAIT: the late alu_done must be ignored.
      alu_lat = 8;
      base = txq.size();
      send_str("6+1=");
      send_byte(8'h49);
      repeat (30) @(negedge clk);
      chk("abort_wait/tx", txq.size() - base, 0);
      chk("abort_wait/busy", int'(bus.seq_busy), 0);
      alu_lat = 3;
      run_expr("after_abort", "9-2=", 9, 2, 1, 1'b0);

      // Reset while waiting on the ALU.
      alu_mute = 1'b1;
      send_str("8+8=");
      repeat (2) @(negedge clk);
      chk("wait/busy", int'(bus.seq_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstwait/alu_a", int'(bus.alu_a), 0);
      chk("rstwait/alu_b", int'(bus.alu_b), 0);
      chk("rstwait/alu_start", int'(bus.alu_start), 0);
      chk("rstwait/seq_busy", int'(bus.seq_busy), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      alu_mute = 1'b0;
      run_expr("after_rst", "3+4=", 3, 4, 0, 1'b0);

      for (int it = 0; it < 24; it++) begin
         a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 9999);
         b  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 9999);
         op = $urandom_range(0, 3);
         case (op)
            0: opc = "+";
            1: opc = "-";
            2: opc = "*";
            default: opc = "/";
         endcase
         s = $sformatf("%s%0d%s%s%s%0d=", (a < 100 && $urandom_range(0, 1) == 1) ? "0" : "",
                       a, ($urandom_range(0, 1) == 1) ? " " : "", opc,
                       ($urandom_range(0, 1) == 1) ? " " : "", b);
         alu_lat = $urandom_range(1, 6);
         run_expr($sformatf("rnd%0d", it), s, a, b, op, 1'b0);
      end

      chk("tx_spacing", spacing_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Command sequencer for the UART calculator. It takes ASCII bytes from the UART receiver and parses an `<operand><op><operand>=` expression. It issues the operation to the shared ALU through a start/done handshake, converts the binary result to decimal, and streams the result characters to the UART transmitter one byte at a time. It sits between the RX byte interface and the TX byte interface inside `top`.

## Interface

**Parameters**
- `DW`, default 16: operand and result width (unsigned).
- `MAX_DIGITS`, default 4: maximum decimal digits accepted per operand.

**Ports**
- `clk` in, 1: system clock, all logic on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `rx_data` in, 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in, 1: one-cycle pulse per received byte.
- `alu_a` out, DW: first operand, held stable while `alu_busy`.
- `alu_b` out, DW: second operand.
- `alu_op` out, 2: operation code: 00 add, 01 sub, 10 mul, 11 div.
- `alu_start` out, 1: one-cycle launch pulse.
- `alu_done` in, 1: one-cycle pulse, result valid in the same cycle.
- `alu_result` in, DW: ALU result.
- `alu_err` in, 1: qualified by `alu_done`; divide-by-zero or overflow.
- `tx_data` out, 8: byte to transmit, held until the next `tx_start`.
- `tx_start` out, 1: one-cycle pulse; issue only when `tx_busy`=0.
- `tx_busy` in, 1: TX busy; rises in the cycle after `tx_start`.
- `seq_busy` out, 1: high in states EXEC, WAIT, CONV and SEND.

## Operation

**States:** OPA, OPB, EXEC, WAIT, CONV, SEND.

**Parsing (OPA, OPB)**
- Digit 0x30–0x39: `acc <= acc*10 + (rx_data-0x30)`, `dcnt++`.
- A digit arriving when `dcnt==MAX_DIGITS` is an error.
- Space 0x20 is ignored in every state.
- 0x49 'I' in any state clears `acc`, `dcnt`, operands and flags, and returns to OPA. It also aborts EXEC/WAIT/CONV/SEND; a later stray `alu_done` is ignored.

**Transitions**
- OPA: operator 0x2B/0x2D/0x2A/0x2F with `dcnt>0` latches A=`acc` and `alu_op`, clears `acc`/`dcnt`, and goes to OPB.
- OPB: 0x3D '=' with `dcnt>0` latches B and goes to EXEC.
- Any other byte in OPA/OPB, an operator in OPB, or '=' in OPA is an error.

**EXEC**
- For sub with A<B, drive `alu_a`=B, `alu_b`=A and set `neg`. Otherwise drive `alu_a`=A, `alu_b`=B.
- Pulse `alu_start`, then go to WAIT.

**WAIT**
- On `alu_done`: if `alu_err`, raise the error; else latch `alu_result` and go to CONV.

**CONV**
- Double-dabble binary-to-BCD, one shift per cycle, exactly DW cycles. Produces `ceil(DW*log10 2)` BCD digits (5 for DW=16).

**SEND**
- Builds the character queue: '-' (0x2D) if `neg`, then the digits MSD-first with leading zeros suppressed, then 0x0D.
- A zero result sends the single digit '0'.

**Error handling**
- Any error loads the queue with 'E' (0x45), 0x0D and enters SEND.

**Other rules**
- `rx_valid` bytes other than 'I' are dropped while in EXEC/WAIT/CONV/SEND.
- After the last character has been started, return to OPA with all registers cleared.

## Timing

**Reset values:** all outputs 0, state OPA, `acc`/`dcnt`/`neg` 0. `rst` wins over every simultaneous event.

**Latencies**
- '=' byte accepted at edge N: EXEC at N+1, `alu_start` high in cycle N+1, WAIT from N+2.
- `alu_done` at edge M: CONV occupies cycles M+1 through M+DW, SEND entered at M+DW+1.
- First `tx_start` in the first SEND cycle where `tx_busy`=0.

**TX handshake**
- After each `tx_start`, wait for `tx_busy` to rise and then fall before the next start.
- Never pulse `tx_start` in two consecutive cycles.

**Abort and reset**
- An 'I' abort mid-SEND stops further `tx_start` pulses; a byte already in flight completes in the TX.
- Reset mid-operation returns to OPA with outputs at their reset values.

**Arithmetic:** `acc` is DW bits wide. With the MAX_DIGITS limit it never wraps (9999 < 2^16).

## Test plan

- "12+34=" → `alu_start` with a=12, b=34, op=00; `alu_result`=46 → TX bytes 0x34 0x36 0x0D.
- "5-9=" → `alu_a`=9, `alu_b`=5, op=01; result 4 → TX 0x2D 0x34 0x0D.
- "7/0=" with `alu_err`=1 → TX 0x45 0x0D, then back in OPA; a following "2*3=" with result 6 → TX 0x36 0x0D.
- "12345" → error on the fifth digit → TX 0x45 0x0D, with no `alu_start`.
- "0 * 0 =" (with spaces) → op=10; result 0 → TX 0x30 0x0D. Also check `tx_start` spacing against a TX model with `tx_busy` held for 10 cycles.
- Abort and reset: 'I' during SEND after the first digit → no further `tx_start`, state OPA. `rst` asserted during WAIT → all outputs 0, and the next expression computes correctly.
